// File: rtl/xswitch_pkg.sv
// ---------------------------------------------------------------------------
// xswitch_pkg
// Shared types and helpers for the crossbar switch request/response paths.
//   N_TGT_DEF / AW_DEF / DW_DEF : default target count, address and data widths
//   xswitch_entry_t             : one queued request {tgt onehot, addr, wdata, we}
//   tsel_width()                : width of the target-select field for n targets
//   onehot_encode()             : target index -> onehot target vector
// ---------------------------------------------------------------------------
package xswitch_pkg;

   localparam int N_TGT_DEF = 5;
   localparam int AW_DEF    = 32;
   localparam int DW_DEF    = 32;

   // The queued request. tgt is always exactly one-hot for a stored entry,
   // which lets the ingress treat "tgt != 0" as "entry present".
   typedef struct packed {
      logic [N_TGT_DEF-1:0] tgt;
      logic [AW_DEF-1:0]    addr;
      logic [DW_DEF-1:0]    wdata;
      logic                 we;
   } xswitch_entry_t;

   // A single target still needs a one-bit select field so the slice of the
   // address stays legal.
   function automatic int tsel_width(input int n_tgt);
      return (n_tgt > 1) ? $clog2(n_tgt) : 1;
   endfunction

   // Out-of-range indices yield all zeros; callers only store in-range ones.
   function automatic logic [N_TGT_DEF-1:0] onehot_encode(input logic [31:0] tsel);
      logic [N_TGT_DEF-1:0] oh;
      for (int i = 0; i < N_TGT_DEF; i++) begin
         oh[i] = (tsel == 32'(i));
      end
      return oh;
   endfunction

endpackage

// File: rtl/xswitch_sync_fifo.sv
// ---------------------------------------------------------------------------
// xswitch_sync_fifo
// Small synchronous FIFO with registered storage, shared by the request and
// response paths.
//   clk, rst : clock, synchronous active-high reset
//   push     : write wdata (ignored when full)
//   wdata    : entry to write
//   pop      : drop the head entry (ignored when empty)
//   rdata    : current head entry (storage contents, stale when empty)
//   level    : occupancy 0..DEPTH
//   full     : level == DEPTH
//   empty    : level == 0
// Push and pop in the same cycle are both honoured; order is preserved.
// DEPTH must be a power of two so the pointers wrap by overflow.
// ---------------------------------------------------------------------------
module xswitch_sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push,
   input  logic [WIDTH-1:0]         wdata,
   input  logic                     pop,
   output logic [WIDTH-1:0]         rdata,
   output logic [$clog2(DEPTH):0]   level,
   output logic                     full,
   output logic                     empty
);

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int LVL_W = $clog2(DEPTH) + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign full    = (level == LVL_W'(DEPTH));
   assign empty   = (level == '0);
   assign do_push = push & ~full;
   assign do_pop  = pop & ~empty;
   assign rdata   = mem[rd_ptr];

   // Pointer and occupancy bookkeeping. A push and pop together leave the
   // level unchanged while both pointers advance.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
      end else begin
         if (do_push) begin
            wr_ptr <= wr_ptr + PTR_W'(1);
         end
         if (do_pop) begin
            rd_ptr <= rd_ptr + PTR_W'(1);
         end
         case ({do_push, do_pop})
            2'b10:   level <= level + LVL_W'(1);
            2'b01:   level <= level - LVL_W'(1);
            default: level <= level;
         endcase
      end
   end

   // Storage is not reset; the pointers alone define which slots are live.
   always_ff @(posedge clk) begin
      if (do_push) begin
         mem[wr_ptr] <= wdata;
      end
   end

endmodule

// File: rtl/xswitch_req_ingress.sv
// ---------------------------------------------------------------------------
// xswitch_req_ingress
// Per-initiator request ingress of the crossbar: accepts transactions,
// decodes the target from the top address bits, queues them and presents the
// head to the arbiter as a onehot0 request held until granted.
//   clk, rst        : clock, synchronous active-high reset
//   in_valid/ready  : initiator handshake (ready = FIFO not full)
//   in_addr/wdata/we: transaction payload
//   req             : onehot0 target request of the head entry
//   vreq            : grant vector from the arbiter
//   out_addr/wdata/we: head-entry payload toward the data mux (0 when empty)
//   out_fire        : head entry granted this cycle
//   dec_err         : one-cycle pulse after a transaction with a bad target
//   starve          : head has waited STARVE_LIM cycles without a grant
//   level           : FIFO occupancy
// The entry layout comes from xswitch_pkg, so N_TGT/AW/DW must match it.
// ---------------------------------------------------------------------------
module xswitch_req_ingress
   import xswitch_pkg::*;
#(
   parameter int N_TGT      = N_TGT_DEF,
   parameter int AW         = AW_DEF,
   parameter int DW         = DW_DEF,
   parameter int DEPTH      = 4,
   parameter int STARVE_LIM = 64
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [AW-1:0]          in_addr,
   input  logic [DW-1:0]          in_wdata,
   input  logic                   in_we,
   output logic [N_TGT-1:0]       req,
   input  logic [N_TGT-1:0]       vreq,
   output logic [AW-1:0]          out_addr,
   output logic [DW-1:0]          out_wdata,
   output logic                   out_we,
   output logic                   out_fire,
   output logic                   dec_err,
   output logic                   starve,
   output logic [$clog2(DEPTH):0] level
);

   localparam int TSEL_W  = tsel_width(N_TGT);
   localparam int ENTRY_W = $bits(xswitch_entry_t);
   localparam int CNT_W   = $clog2(STARVE_LIM + 1);

   logic [TSEL_W-1:0]  tsel;
   logic               tsel_ok;
   logic               accept;
   logic               push;
   logic               fifo_full;
   logic               fifo_empty;
   logic [ENTRY_W-1:0] head_bits;
   xswitch_entry_t     push_entry;
   xswitch_entry_t     head_entry;
   logic [CNT_W-1:0]   wait_cnt;

   assign tsel     = in_addr[AW-1 -: TSEL_W];
   assign tsel_ok  = (32'(tsel) < N_TGT);
   assign in_ready = ~fifo_full;
   assign accept   = in_valid & in_ready;
   assign push     = accept & tsel_ok;

   // Decode happens once, at push time; the stored one-hot is what the
   // arbiter sees, so the address is never re-decoded downstream.
   always_comb begin
      push_entry       = '0;
      push_entry.tgt   = onehot_encode(32'(tsel));
      push_entry.addr  = in_addr;
      push_entry.wdata = in_wdata;
      push_entry.we    = in_we;
   end

   xswitch_sync_fifo #(
      .WIDTH (ENTRY_W),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push),
      .wdata (push_entry),
      .pop   (out_fire),
      .rdata (head_bits),
      .level (level),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   // Masking the head with empty keeps req and the payload at zero when
   // nothing is queued, instead of exposing stale storage.
   always_comb begin
      head_entry = '0;
      if (!fifo_empty) begin
         head_entry = xswitch_entry_t'(head_bits);
      end
   end

   assign req       = head_entry.tgt;
   assign out_addr  = head_entry.addr;
   assign out_wdata = head_entry.wdata;
   assign out_we    = head_entry.we;
   assign out_fire  = |(req & vreq);
   assign starve    = (wait_cnt == CNT_W'(STARVE_LIM));

   // A dropped transaction still completes its handshake; the only trace it
   // leaves is this registered one-cycle flag.
   always_ff @(posedge clk) begin
      if (rst) begin
         dec_err <= 1'b0;
      end else begin
         dec_err <= accept & ~tsel_ok;
      end
   end

   // Wait counter for the current head. A non-empty FIFO always has a
   // non-zero req, so "not empty and not fired" is "waiting". It saturates
   // so starve stays up until the head finally goes.
   always_ff @(posedge clk) begin
      if (rst) begin
         wait_cnt <= '0;
      end else if (out_fire || fifo_empty) begin
         wait_cnt <= '0;
      end else if (wait_cnt != CNT_W'(STARVE_LIM)) begin
         wait_cnt <= wait_cnt + CNT_W'(1);
      end
   end

`ifndef SYNTHESIS
   logic           chk_hold;
   xswitch_entry_t chk_head;

   // Simulation-only protocol checks: onehot0 request, a pending head that
   // does not move until fired, bounded occupancy, and no push into a full FIFO.
   always_ff @(posedge clk) begin
      if (rst) begin
         chk_hold <= 1'b0;
         chk_head <= '0;
      end else begin
         chk_hold <= (req != '0) && !out_fire;
         chk_head <= head_entry;
         assert ($onehot0(req));
         assert (32'(level) <= DEPTH);
         assert (!(push && fifo_full));
         if (chk_hold) begin
            assert (head_entry == chk_head);
         end
      end
   end
`endif

endmodule

// File: tb/tb_xswitch_req_ingress.sv
// ---------------------------------------------------------------------------
// tb_xswitch_req_ingress
// Self-checking bench: a directed vector table, starvation and reset
// sequences, then randomized traffic. A queue-based model of the ingress
// supplies every expected output each cycle.
// ---------------------------------------------------------------------------
module tb_xswitch_req_ingress;

   localparam int N_TGT      = 5;
   localparam int AW         = 32;
   localparam int DW         = 32;
   localparam int DEPTH      = 4;
   localparam int STARVE_LIM = 64;

   logic          clk = 1'b0;
   logic          rst;
   logic          in_valid;
   logic          in_ready;
   logic [AW-1:0] in_addr;
   logic [DW-1:0] in_wdata;
   logic          in_we;
   logic [4:0]    req;
   logic [4:0]    vreq;
   logic [AW-1:0] out_addr;
   logic [DW-1:0] out_wdata;
   logic          out_we;
   logic          out_fire;
   logic          dec_err;
   logic          starve;
   logic [2:0]    level;

   int total = 0;
   int bad   = 0;

   typedef struct {
      int          tgt;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic        we;
   } model_entry_t;

   model_entry_t mq[$];
   logic         m_dec;
   int           m_wait;

   typedef struct {
      logic        valid;
      logic [31:0] addr;
      logic        we;
      logic [4:0]  vreq;
      logic        exp_ready;
      logic [4:0]  exp_req;
      logic        exp_fire;
      logic [2:0]  exp_level;
      logic        exp_dec;
   } vec_t;

   vec_t vecs[23];

   // Free-running clock; inputs change on the falling edge.
   always #5 clk = ~clk;

   xswitch_req_ingress #(
      .N_TGT      (N_TGT),
      .AW         (AW),
      .DW         (DW),
      .DEPTH      (DEPTH),
      .STARVE_LIM (STARVE_LIM)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_addr   (in_addr),
      .in_wdata  (in_wdata),
      .in_we     (in_we),
      .req       (req),
      .vreq      (vreq),
      .out_addr  (out_addr),
      .out_wdata (out_wdata),
      .out_we    (out_we),
      .out_fire  (out_fire),
      .dec_err   (dec_err),
      .starve    (starve),
      .level     (level)
   );

   task automatic compare(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("[TB] FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [4:0] modelReq();
      logic [4:0] r;
      r = 5'b00000;
      if (mq.size() > 0) begin
         r = 5'b00001 << mq[0].tgt;
      end
      return r;
   endfunction

   task automatic applyStimulus(input logic r, input logic v, input logic [31:0] a,
                                input logic [31:0] d, input logic w, input logic [4:0] g);
      rst      = r;
      in_valid = v;
      in_addr  = a;
      in_wdata = d;
      in_we    = w;
      vreq     = g;
      #1;
   endtask

   task automatic checkOutput();
      logic [4:0]  e_req;
      logic [31:0] e_addr;
      logic [31:0] e_wdata;
      logic        e_we;
      e_req   = modelReq();
      e_addr  = '0;
      e_wdata = '0;
      e_we    = 1'b0;
      if (mq.size() > 0) begin
         e_addr  = mq[0].addr;
         e_wdata = mq[0].wdata;
         e_we    = mq[0].we;
      end
      compare("in_ready",  64'(in_ready),  64'(mq.size() < DEPTH));
      compare("req",       64'(req),       64'(e_req));
      compare("out_fire",  64'(out_fire),  64'(|(e_req & vreq)));
      compare("out_addr",  64'(out_addr),  64'(e_addr));
      compare("out_wdata", 64'(out_wdata), 64'(e_wdata));
      compare("out_we",    64'(out_we),    64'(e_we));
      compare("dec_err",   64'(dec_err),   64'(m_dec));
      compare("starve",    64'(starve),    64'(m_wait >= STARVE_LIM));
      compare("level",     64'(level),     64'(mq.size()));
   endtask

   // Advance the model across the rising edge using the inputs currently
   // applied, then move to the next falling edge.
   task automatic tick();
      logic         fire;
      logic         acc;
      int           n;
      int           tsel;
      model_entry_t e;
      n    = mq.size();
      fire = |(modelReq() & vreq);
      acc  = in_valid && (n < DEPTH);
      tsel = int'(in_addr[31:29]);
      if (rst) begin
         mq.delete();
         m_dec  = 1'b0;
         m_wait = 0;
      end else begin
         m_dec = acc && (tsel >= N_TGT);
         if (fire) begin
            void'(mq.pop_front());
         end
         if (acc && (tsel < N_TGT)) begin
            e.tgt   = tsel;
            e.addr  = in_addr;
            e.wdata = in_wdata;
            e.we    = in_we;
            mq.push_back(e);
         end
         if (fire || (n == 0)) begin
            m_wait = 0;
         end else if (m_wait < STARVE_LIM) begin
            m_wait++;
         end
      end
      @(posedge clk);
      @(negedge clk);
   endtask

   initial begin
      // valid, addr, we, vreq, exp_ready, exp_req, exp_fire, exp_level, exp_dec
      vecs[0]  = '{1'b1, 32'h4000_0000, 1'b1, 5'b00000, 1'b1, 5'b00000, 1'b0, 3'd0, 1'b0};
      vecs[1]  = '{1'b0, 32'h0000_0000, 1'b0, 5'b00100, 1'b1, 5'b00100, 1'b1, 3'd1, 1'b0};
      vecs[2]  = '{1'b0, 32'h0000_0000, 1'b0, 5'b00000, 1'b1, 5'b00000, 1'b0, 3'd0, 1'b0};
      vecs[3]  = '{1'b1, 32'h0000_1000, 1'b0, 5'b00000, 1'b1, 5'b00000, 1'b0, 3'd0, 1'b0};
      vecs[4]  = '{1'b1, 32'h2000_0010, 1'b1, 5'b00000, 1'b1, 5'b00001, 1'b0, 3'd1, 1'b0};
      vecs[5]  = '{1'b1, 32'h6000_0020, 1'b0, 5'b00000, 1'b1, 5'b00001, 1'b0, 3'd2, 1'b0};
      vecs[6]  = '{1'b1, 32'h8000_0030, 1'b1, 5'b00000, 1'b1, 5'b00001, 1'b0, 3'd3, 1'b0};
      vecs[7]  = '{1'b1, 32'h4000_0040, 1'b0, 5'b00000, 1'b0, 5'b00001, 1'b0, 3'd4, 1'b0};
      vecs[8]  = '{1'b0, 32'h0000_0000, 1'b0, 5'b00010, 1'b0, 5'b00001, 1'b0, 3'd4, 1'b0};
      vecs[9]  = '{1'b1, 32'h4000_0050, 1'b1, 5'b00001, 1'b0, 5'b00001, 1'b1, 3'd4, 1'b0};
      vecs[10] = '{1'b0, 32'h0000_0000, 1'b0, 5'b00010, 1'b1, 5'b00010, 1'b1, 3'd3, 1'b0};
      vecs[11] = '{1'b0, 32'h0000_0000, 1'b0, 5'b01000, 1'b1, 5'b01000, 1'b1, 3'd2, 1'b0};
      vecs[12] = '{1'b0, 32'h0000_0000, 1'b0, 5'b10000, 1'b1, 5'b10000, 1'b1, 3'd1, 1'b0};
      vecs[13] = '{1'b0, 32'h0000_0000, 1'b0, 5'b00000, 1'b1, 5'b00000, 1'b0, 3'd0, 1'b0};
      vecs[14] = '{1'b1, 32'hE000_0000, 1'b1, 5'b00000, 1'b1, 5'b00000, 1'b0, 3'd0, 1'b0};
      vecs[15] = '{1'b0, 32'h0000_0000, 1'b0, 5'b00000, 1'b1, 5'b00000, 1'b0, 3'd0, 1'b1};
      vecs[16] = '{1'b0, 32'h0000_0000, 1'b0, 5'b00000, 1'b1, 5'b00000, 1'b0, 3'd0, 1'b0};
      vecs[17] = '{1'b1, 32'h4000_0060, 1'b0, 5'b00000, 1'b1, 5'b00000, 1'b0, 3'd0, 1'b0};
      vecs[18] = '{1'b0, 32'h0000_0000, 1'b0, 5'b00010, 1'b1, 5'b00100, 1'b0, 3'd1, 1'b0};
      vecs[19] = '{1'b0, 32'h0000_0000, 1'b0, 5'b00010, 1'b1, 5'b00100, 1'b0, 3'd1, 1'b0};
      vecs[20] = '{1'b0, 32'h0000_0000, 1'b0, 5'b11011, 1'b1, 5'b00100, 1'b0, 3'd1, 1'b0};
      vecs[21] = '{1'b0, 32'h0000_0000, 1'b0, 5'b00100, 1'b1, 5'b00100, 1'b1, 3'd1, 1'b0};
      vecs[22] = '{1'b0, 32'h0000_0000, 1'b0, 5'b00000, 1'b1, 5'b00000, 1'b0, 3'd0, 1'b0};

      rst      = 1'b1;
      in_valid = 1'b0;
      in_addr  = '0;
      in_wdata = '0;
      in_we    = 1'b0;
      vreq     = '0;
      m_dec    = 1'b0;
      m_wait   = 0;
      repeat (3) @(posedge clk);
      @(negedge clk);

      $display("[TB] directed vector table");
      for (int i = 0; i < 23; i++) begin
         applyStimulus(1'b0, vecs[i].valid, vecs[i].addr, 32'hD000_0000 + 32'(i),
                       vecs[i].we, vecs[i].vreq);
         checkOutput();
         compare($sformatf("v%0d_ready", i), 64'(in_ready), 64'(vecs[i].exp_ready));
         compare($sformatf("v%0d_req",   i), 64'(req),      64'(vecs[i].exp_req));
         compare($sformatf("v%0d_fire",  i), 64'(out_fire), 64'(vecs[i].exp_fire));
         compare($sformatf("v%0d_level", i), 64'(level),    64'(vecs[i].exp_level));
         compare($sformatf("v%0d_dec",   i), 64'(dec_err),  64'(vecs[i].exp_dec));
         tick();
      end

      $display("[TB] starvation sequence");
      applyStimulus(1'b0, 1'b1, 32'h2000_0100, 32'h5555_0001, 1'b1, 5'b00000);
      checkOutput();
      tick();
      for (int k = 1; k <= STARVE_LIM; k++) begin
         applyStimulus(1'b0, 1'b0, '0, '0, 1'b0, 5'b00000);
         checkOutput();
         if (k == STARVE_LIM) begin
            compare("starve_before_lim", 64'(starve), 64'(0));
         end
         tick();
      end
      applyStimulus(1'b0, 1'b0, '0, '0, 1'b0, 5'b00010);
      checkOutput();
      compare("starve_at_lim", 64'(starve), 64'(1));
      compare("starve_grant_fire", 64'(out_fire), 64'(1));
      tick();
      applyStimulus(1'b0, 1'b0, '0, '0, 1'b0, 5'b00000);
      checkOutput();
      compare("starve_after_grant", 64'(starve), 64'(0));
      tick();

      $display("[TB] reset with queued entries");
      applyStimulus(1'b0, 1'b1, 32'h0000_0200, 32'h7777_0001, 1'b0, 5'b00000);
      checkOutput();
      tick();
      applyStimulus(1'b0, 1'b1, 32'h6000_0300, 32'h7777_0002, 1'b1, 5'b00000);
      checkOutput();
      tick();
      applyStimulus(1'b0, 1'b1, 32'h8000_0400, 32'h7777_0003, 1'b0, 5'b00000);
      checkOutput();
      tick();
      applyStimulus(1'b1, 1'b0, '0, '0, 1'b0, 5'b00000);
      checkOutput();
      compare("pre_rst_level", 64'(level), 64'(3));
      tick();
      applyStimulus(1'b0, 1'b0, '0, '0, 1'b0, 5'b00000);
      checkOutput();
      compare("post_rst_level", 64'(level),    64'(0));
      compare("post_rst_req",   64'(req),      64'(0));
      compare("post_rst_ready", 64'(in_ready), 64'(1));
      tick();

      $display("[TB] randomized traffic");
      for (int c = 0; c < 1500; c++) begin
         logic [4:0] g;
         case ($urandom_range(0, 3))
            0:       g = 5'b00000;
            1:       g = 5'($urandom);
            default: g = modelReq();
         endcase
         applyStimulus(($urandom_range(0, 149) == 0), ($urandom_range(0, 9) < 6),
                       $urandom, $urandom, 1'($urandom_range(0, 1)), g);
         checkOutput();
         tick();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
